// File: rtl/ring_seq_monitor.sv
// ring_seq_monitor: receive-side checker for a one-hot rotating ring pattern.
// The set bit moves from bit i to bit i-1 each step, with bit 0 wrapping to
// bit WIDTH-1. The monitor locks onto the sequence, decodes the current
// phase to a binary index, counts completed rotations and flags violations.
// Optional feature macro: RING_HOLD_ALLOW_EN (repeated phase accepted as a
// hold instead of a violation, for producers with a slower ring clock).
// Handshake: sample_en has no backpressure; a high sample_en at a posedge
// captures ring_in as exactly one ring step, evaluated on the following edge.
module ring_seq_monitor #(
    parameter int WIDTH     = 4,
    parameter int IDX_W     = 2,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8,
    parameter int ROT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     ring_in,
    input  logic                 sample_en,
    output logic [IDX_W-1:0]     idx,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ROT_W-1:0]     rot_cnt
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // state is kept as a plain named signal so checkers can bind to it
    state_t                 state, state_next;
    logic [WIDTH-1:0]       sample_q;
    logic                   sample_v;
    logic [GOOD_W-1:0]      good, good_next;
    logic [IDX_W-1:0]       idx_q, idx_next;
    logic                   err_q, err_next;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_next;
    logic [ROT_W-1:0]       rot_q, rot_next;

    logic [IDX_W-1:0]       cur;
    logic [IDX_W-1:0]       exp_step;
    logic                   onehot;
    logic                   is_step;
    logic                   is_hold;
    logic                   is_bad;

    // Input stage: capture one ring step per sample_en, valid bit alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            sample_v <= 1'b0;
        end else begin
            sample_v <= sample_en;
            if (sample_en) begin
                sample_q <= ring_in;
            end
        end
    end

    // Decode the set bit position of the registered sample
    always_comb begin
        cur = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sample_q[i]) begin
                cur = IDX_W'(i);
            end
        end
    end

    assign onehot   = ($countones(sample_q) == 1);
    // Expected next phase: one position down, bit 0 wraps to the top
    assign exp_step = (idx_q == '0) ? IDX_W'(WIDTH - 1) : idx_q - IDX_W'(1);
    assign is_step  = onehot && (cur == exp_step);
`ifdef RING_HOLD_ALLOW_EN
    assign is_hold  = onehot && (cur == idx_q);
`else
    assign is_hold  = 1'b0;
`endif
    // Anything that is neither a step nor an accepted hold breaks the sequence
    assign is_bad   = !onehot || (!is_step && !is_hold);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            good      <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            rot_q     <= '0;
        end else begin
            state     <= state_next;
            good      <= good_next;
            idx_q     <= idx_next;
            err_q     <= err_next;
            err_cnt_q <= err_cnt_next;
            rot_q     <= rot_next;
        end
    end

    // Next-state logic: evaluate the registered sample only when it is valid
    always_comb begin
        state_next   = state;
        good_next    = good;
        idx_next     = idx_q;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_q;
        rot_next     = rot_q;
        if (sample_v) begin
            if (onehot) begin
                idx_next = cur;
            end
            case (state)
                HUNT: begin
                    if (onehot) begin
                        state_next = CHECK;
                        good_next  = '0;
                    end
                end
                CHECK: begin
                    if (!onehot) begin
                        state_next = HUNT;
                    end else if (is_step) begin
                        good_next = good + GOOD_W'(1);
                        if (good == GOOD_W'(LOCK_CNT - 1)) begin
                            state_next = LOCKED;
                        end
                    end else if (!is_hold) begin
                        // wrong phase: re-anchor on the new position
                        good_next = '0;
                    end
                end
                LOCKED: begin
                    if (is_bad) begin
                        err_next   = 1'b1;
                        state_next = HUNT;
                        if (err_cnt_q != '1) begin
                            err_cnt_next = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end else if (is_step && (cur == IDX_W'(WIDTH - 1))) begin
                        rot_next = rot_q + ROT_W'(1);
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    assign idx       = idx_q;
    assign locked    = (state == LOCKED);
    assign idx_valid = (state == LOCKED);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign rot_cnt   = rot_q;

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Directed bench for ring_seq_monitor (WIDTH=4, LOCK_CNT=2). A second
// instance with a 2-bit error counter shares the stimulus to cover saturation.
module tb_ring_seq_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ring_in;
    logic        sample_en;

    logic [1:0]  idx,       idx_b;
    logic        idx_valid, idx_valid_b;
    logic        locked,    locked_b;
    logic        err,       err_b;
    logic [7:0]  err_cnt;
    logic [1:0]  err_cnt_b;
    logic [15:0] rot_cnt,   rot_cnt_b;

    int checks = 0;
    int errors = 0;

    logic [3:0] pats [7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010};
    logic [1:0] idxs [7] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
    logic [15:0] rots [7] = '{16'd4, 16'd4, 16'd4, 16'd4, 16'd5, 16'd5, 16'd5};

    ring_seq_monitor #(.WIDTH(4), .IDX_W(2), .LOCK_CNT(2), .ERR_CNT_W(8), .ROT_W(16)) dut (
        .clk(clk), .rst(rst), .ring_in(ring_in), .sample_en(sample_en),
        .idx(idx), .idx_valid(idx_valid), .locked(locked), .err(err),
        .err_cnt(err_cnt), .rot_cnt(rot_cnt)
    );

    ring_seq_monitor #(.WIDTH(4), .IDX_W(2), .LOCK_CNT(2), .ERR_CNT_W(2), .ROT_W(16)) dut_b (
        .clk(clk), .rst(rst), .ring_in(ring_in), .sample_en(sample_en),
        .idx(idx_b), .idx_valid(idx_valid_b), .locked(locked_b), .err(err_b),
        .err_cnt(err_cnt_b), .rot_cnt(rot_cnt_b)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // present one ring step; it is registered on the next edge
    task automatic send(input logic [3:0] pat);
        ring_in   = pat;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // clean sequence from HUNT: 1000 anchors, 0100/0010 lock, 0001 steps (idx 0)
    task automatic relock();
        send(4'b1000);
        send(4'b0100);
        send(4'b0010);
        send(4'b0001);
        tick(1);
    endtask

    initial begin
        rst = 1'b1; ring_in = '0; sample_en = 1'b0;
        tick(2);
        chk("rst_idx", idx, 0);
        chk("rst_idx_valid", idx_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_rot_cnt", rot_cnt, 0);
        rst = 1'b0;

        // clean lock, back-to-back samples; outputs trail by one send
        send(4'b1000);
        chk("lock_s1_locked", locked, 0);
        send(4'b0100);
        chk("lock_idx3", idx, 3);
        chk("lock_s2_locked", locked, 0);
        send(4'b0010);
        chk("lock_idx2", idx, 2);
        chk("lock_s3_locked", locked, 0);
        send(4'b0001);
        chk("lock_idx1", idx, 1);
        chk("lock_rise", locked, 1);
        chk("lock_idx_valid", idx_valid, 1);
        send(4'b1000);
        chk("lock_idx0", idx, 0);
        chk("lock_rot0", rot_cnt, 0);
        send(4'b0100);
        chk("lock_idx3b", idx, 3);
        chk("lock_rot1", rot_cnt, 1);
        send(4'b0010);
        send(4'b0001);
        send(4'b1000);
        tick(1);
        chk("lock_rot2", rot_cnt, 2);
        chk("lock_idx3c", idx, 3);
        chk("lock_no_err", err, 0);

        // invalid multi-bit pattern while locked
        send(4'b0110);
        tick(1);
        chk("inv_err", err, 1);
        chk("inv_err_cnt", err_cnt, 1);
        chk("inv_locked", locked, 0);
        chk("inv_idx_valid", idx_valid, 0);
        chk("inv_idx_held", idx, 3);
        tick(1);
        chk("inv_err_pulse_end", err, 0);
        send(4'b0100);
        send(4'b0010);
        send(4'b0001);
        tick(1);
        chk("relock_locked", locked, 1);
        chk("relock_rot_kept", rot_cnt, 2);
        send(4'b1000);
        tick(1);
        chk("relock_rot3", rot_cnt, 3);

        // wrong direction: 0010 then 0100
        send(4'b0100);
        send(4'b0010);
        tick(1);
        chk("wd_pre_locked", locked, 1);
        chk("wd_pre_idx", idx, 1);
        send(4'b0100);
        tick(1);
        chk("wd_err", err, 1);
        chk("wd_err_cnt", err_cnt, 2);
        chk("wd_locked", locked, 0);
        chk("wd_idx", idx, 2);
        chk("wd_err_b", err_b, 1);

        // hold: 0010 sampled twice while locked
        send(4'b1000);
        send(4'b0100);
        send(4'b0010);
        send(4'b0010);
        chk("hold_pre_locked", locked, 1);
        tick(1);
`ifdef RING_HOLD_ALLOW_EN
        chk("hold_no_err", err, 0);
        chk("hold_locked", locked, 1);
        chk("hold_idx", idx, 1);
        chk("hold_err_cnt", err_cnt, 2);
        send(4'b0000);
        tick(1);
        chk("hold_zero_err", err, 1);
`else
        chk("hold_err", err, 1);
        chk("hold_unlock", locked, 0);
        chk("hold_idx", idx, 1);
`endif
        chk("hold_err_cnt_after", err_cnt, 3);
        chk("hold_err_cnt_b", err_cnt_b, 3);

        // saturation of the 2-bit counter
        relock();
        chk("sat_relock", locked, 1);
        chk("sat_relock_idx", idx, 0);
        chk("sat_rot_held", rot_cnt, 3);
        send(4'b0000);
        tick(1);
        chk("sat_zero_err", err, 1);
        chk("sat_err_cnt4", err_cnt, 4);
        chk("sat_b_after4", err_cnt_b, 3);
        relock();
        send(4'b1111);
        tick(1);
        chk("sat_err_cnt5", err_cnt, 5);
        chk("sat_b_after5", err_cnt_b, 3);
        chk("sat_b_unlocked", locked_b, 0);

        // sample_en gaps of 1..7 cycles in a clean sequence
        relock();
        for (int i = 0; i < 7; i++) begin
            send(pats[i]);
            tick(1);
            chk("gap_err", err, 0);
            tick(i);
            chk("gap_locked", locked, 1);
            chk("gap_idx", idx, idxs[i]);
            chk("gap_rot", rot_cnt, rots[i]);
        end
        chk("gap_b_idx", idx_b, 1);
        chk("gap_b_valid", idx_valid_b, 1);
        chk("gap_b_rot", rot_cnt_b, 5);

        // reset mid-lock, with sample_en held high
        ring_in = 4'b0001; sample_en = 1'b1; rst = 1'b1;
        tick(2);
        chk("mrst_locked", locked, 0);
        chk("mrst_idx", idx, 0);
        chk("mrst_idx_valid", idx_valid, 0);
        chk("mrst_err_cnt", err_cnt, 0);
        chk("mrst_rot_cnt", rot_cnt, 0);
        chk("mrst_err_cnt_b", err_cnt_b, 0);
        rst = 1'b0; sample_en = 1'b0;
        send(4'b0100);
        tick(1);
        chk("mrst_check_locked", locked, 0);
        chk("mrst_check_idx", idx, 2);
        send(4'b0010);
        tick(1);
        chk("mrst_good1_locked", locked, 0);
        send(4'b0001);
        tick(1);
        chk("mrst_lock_from_check", locked, 1);
        chk("mrst_lock_idx", idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
